// File: rtl/mem_block.sv
// mem_block: byte-addressable, word-ported synchronous memory for the pd1 MIPS core.
// Big-endian: bits [31:24] of a word sit at the lowest byte address.
// Optional build macro MEM_ACCESS_SIZE_EN adds an access_size port.
// With the macro, access_size selects byte or halfword accesses. Without it,
// every access is a full word.
//
// Interface protocol: there is no valid/ready handshake. When en=1, one access
// is taken on every rising clock edge, and it never stalls. rw selects the
// operation: 1 = read, 0 = write. Read data is registered and appears after
// the edge that sampled the address. When en=0, storage and read data hold.
module mem_block #(
  parameter int DEPTH_BYTES   = 1048576,
  parameter int ADDR_LSB_BITS = 20
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] w_addr_32,
  input  logic [31:0] w_data_in_32,
  output logic [31:0] w_data_out_32,
  input  logic        rw,
  input  logic        en
`ifdef MEM_ACCESS_SIZE_EN
  ,
  input  logic [1:0]  access_size
`endif
);

  // Storage is never reset. Its initial contents are undefined.
  logic [7:0] mem [DEPTH_BYTES];

  // Byte indices for the four lanes. The narrow index width makes wrap modulo
  // DEPTH_BYTES happen for free.
  logic [ADDR_LSB_BITS-1:0] idx0;
  logic [ADDR_LSB_BITS-1:0] idx1;
  logic [ADDR_LSB_BITS-1:0] idx2;
  logic [ADDR_LSB_BITS-1:0] idx3;

  assign idx0 = w_addr_32[ADDR_LSB_BITS-1:0];
  assign idx1 = idx0 + ADDR_LSB_BITS'(1);
  assign idx2 = idx0 + ADDR_LSB_BITS'(2);
  assign idx3 = idx0 + ADDR_LSB_BITS'(3);

  // Upper address bits alias and are deliberately ignored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^w_addr_32[31:ADDR_LSB_BITS];

  // Access decode. rd_word is the value captured on a read.
  // lane_we and lane_data carry per-lane write enables and data,
  // with lane 0 at the lowest address.
  logic        do_write;
  logic        do_read;
  logic [3:0]  lane_we;
  logic [7:0]  lane_data [4];
  logic [31:0] rd_word;

  assign do_write = en && !rw;
  assign do_read  = en && rw;

  // Select lane enables, lane write data and read data for the access size.
  always_comb begin
    lane_we      = 4'b1111;
    lane_data[0] = w_data_in_32[31:24];
    lane_data[1] = w_data_in_32[23:16];
    lane_data[2] = w_data_in_32[15:8];
    lane_data[3] = w_data_in_32[7:0];
    rd_word      = {mem[idx0], mem[idx1], mem[idx2], mem[idx3]};
`ifdef MEM_ACCESS_SIZE_EN
    case (access_size)
      2'b00: begin
        lane_we      = 4'b0001;
        lane_data[0] = w_data_in_32[7:0];
        rd_word      = {24'h0, mem[idx0]};
      end
      2'b01: begin
        lane_we      = 4'b0011;
        lane_data[0] = w_data_in_32[15:8];
        lane_data[1] = w_data_in_32[7:0];
        rd_word      = {16'h0, mem[idx0], mem[idx1]};
      end
      default: begin
        lane_we = 4'b1111;
      end
    endcase
`endif
  end

  // Byte-lane writes into storage. Only the addressed bytes are touched.
  always_ff @(posedge clock) begin
    if (do_write) begin
      if (lane_we[0]) mem[idx0] <= lane_data[0];
      if (lane_we[1]) mem[idx1] <= lane_data[1];
      if (lane_we[2]) mem[idx2] <= lane_data[2];
      if (lane_we[3]) mem[idx3] <= lane_data[3];
    end
  end

  // Registered read data. It is cleared by reset and holds on writes and idle cycles.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      w_data_out_32 <= 32'h0;
    end else if (do_read) begin
      w_data_out_32 <= rd_word;
    end
  end

endmodule

// File: tb/tb_mem_block.sv
// tb_mem_block: directed bench for mem_block in the default word-only build.
module tb_mem_block;

  localparam int DEPTH = 1048576;
  localparam int W     = 32;

  logic          clock;
  logic          reset_n;
  logic [31:0]   w_addr_32;
  logic [31:0]   w_data_in_32;
  logic [31:0]   w_data_out_32;
  logic          rw;
  logic          en;
`ifdef MEM_ACCESS_SIZE_EN
  logic [1:0]    access_size;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_w;

  mem_block #(.DEPTH_BYTES(DEPTH), .ADDR_LSB_BITS(20)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .w_addr_32     (w_addr_32),
    .w_data_in_32  (w_data_in_32),
    .w_data_out_32 (w_data_out_32),
    .rw            (rw),
    .en            (en)
`ifdef MEM_ACCESS_SIZE_EN
    ,
    .access_size   (access_size)
`endif
  );

  // Clock generation: 10 time-unit period.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Compare the observed value against the expected value. Every call counts once.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Drive one access at the falling edge and let it be taken at the rising edge.
  // Return #1 after that edge, with en already dropped.
  task automatic access(input logic is_read, input logic [31:0] addr, input logic [31:0] data);
    @(negedge clock);
    en           = 1'b1;
    rw           = is_read;
    w_addr_32    = addr;
    w_data_in_32 = data;
    @(posedge clock);
    #1;
    en = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    access(1'b0, addr, data);
  endtask

  task automatic rd(input logic [31:0] addr);
    access(1'b1, addr, 32'h0);
  endtask

  initial begin
    reset_n      = 1'b1;
    en           = 1'b0;
    rw           = 1'b1;
    w_addr_32    = 32'h0;
    w_data_in_32 = 32'h0;
`ifdef MEM_ACCESS_SIZE_EN
    access_size  = 2'b10;
`endif
    #1 reset_n = 1'b0;
    #12;
    check("reset_out", w_data_out_32, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;

    // Basic word writes and reads.
    wr(32'h0, 32'hABCDABCD);
    wr(32'h4, 32'hDEFADEFA);
    wr(32'h8, 32'h12341234);
    check("out_zero_after_writes", w_data_out_32, 32'h0);
    rd(32'h0); check("rd_0", w_data_out_32, 32'hABCDABCD);
    rd(32'h4); check("rd_4", w_data_out_32, 32'hDEFADEFA);
    rd(32'h8); check("rd_8", w_data_out_32, 32'h12341234);
    wr(32'hC, 32'h0BADF00D);
    check("hold_on_write", w_data_out_32, 32'h12341234);
    rd(32'hC); check("rd_after_wr", w_data_out_32, 32'h0BADF00D);

    // Asynchronous reset mid-cycle; storage contents must survive.
    rd(32'h0); check("pre_reset_rd", w_data_out_32, 32'hABCDABCD);
    #2 reset_n = 1'b0;
    #1 check("async_reset", w_data_out_32, 32'h0);
    @(posedge clock); #1;
    check("reset_held", w_data_out_32, 32'h0);
    @(negedge clock); reset_n = 1'b1;
    rd(32'h0); check("contents_kept", w_data_out_32, 32'hABCDABCD);

    // Bulk load: 64 words, then a back-to-back sweep at +4.
    for (int i = 0; i < 64; i++) begin
      wr(32'(4 * i), 32'h1000_0000 + 32'(i));
      exp_q.push_back(32'h1000_0000 + 32'(i));
    end
    @(negedge clock);
    en = 1'b1;
    rw = 1'b1;
    w_addr_32 = 32'h0;
    for (int i = 0; i < 64; i++) begin
      @(posedge clock); #1;
      exp_w = exp_q.pop_front();
      check($sformatf("bulk_%0d", i), w_data_out_32, exp_w);
      w_addr_32 = w_addr_32 + 32'd4;
    end
    en = 1'b0;

    // Unaligned accesses and big-endian byte order.
    wr(32'h0, 32'h11223344);
    wr(32'h4, 32'h55667788);
    rd(32'h2); check("unaligned_2", w_data_out_32, 32'h33445566);
    rd(32'h1); check("unaligned_1", w_data_out_32, 32'h22334455);
    rd(32'h0); check("word_0", w_data_out_32, 32'h11223344);

    // Wrap at the top of storage, and aliasing through the upper address bits.
    wr(32'(DEPTH - 2), 32'hCAFEBABE);
    rd(32'h0); check("wrap_low_half", {16'h0, w_data_out_32[31:16]}, 32'h0000BABE);
    rd(32'(DEPTH + DEPTH - 2)); check("alias_wrap", w_data_out_32, 32'hCAFEBABE);
    rd(32'(DEPTH - 4)); check("top_bytes", {16'h0, w_data_out_32[15:0]}, 32'h0000CAFE);

    // Enable gating: a write pattern with en=0 must change nothing.
    rd(32'h0); check("gate_pre", w_data_out_32, 32'hBABE3344);
    @(negedge clock);
    en = 1'b0;
    rw = 1'b0;
    w_addr_32 = 32'h0;
    w_data_in_32 = 32'hFFFFFFFF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      check($sformatf("gate_hold_%0d", i), w_data_out_32, 32'hBABE3344);
    end
    rd(32'h0); check("gate_post", w_data_out_32, 32'hBABE3344);
    rd(32'h4); check("gate_neighbor", w_data_out_32, 32'h55667788);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Safety bound so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_block.md
Name: mem_block

Overview:
- Byte-addressable, word-ported synchronous memory for the MIPS CPU (pd1).
- Holds program and data images.
- The bench loads a benchmark word by word through the write path and reads it back sequentially at word strides (address += 4).
- Big-endian byte order, matching MIPS.

Parameters:
- DEPTH_BYTES, 1048576: storage size in bytes; must be a power of two, minimum 16.
- ADDR_LSB_BITS, 20: log2(DEPTH_BYTES); number of address bits used for indexing.

Ports:
- clock  input  1  single clock; all sampling on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- w_addr_32  input  32  byte address of the access.
- w_data_in_32  input  32  write data; bits [31:24] go to the lowest byte address.
- w_data_out_32  output  32  registered read data.
- rw  input  1  1 = read, 0 = write.
- en  input  1  access enable; 0 = no access, output holds.

Behaviour:
- Reset (reset_n low, asynchronous):
  - w_data_out_32 goes to 32'h0 immediately and stays there while reset is asserted.
  - Storage contents are NOT cleared; reset only affects output/control registers.
  - Reset released mid-sequence: the first access happens on the first rising edge with reset_n high.
- Effective byte index is w_addr_32[ADDR_LSB_BITS-1:0]. Upper address bits are ignored, so addresses alias modulo DEPTH_BYTES.
- Write (en=1, rw=0, rising edge):
  - mem[a] <= din[31:24], mem[a+1] <= din[23:16], mem[a+2] <= din[15:8], mem[a+3] <= din[7:0].
  - Index arithmetic wraps modulo DEPTH_BYTES; unaligned addresses are legal.
  - w_data_out_32 holds its previous value during writes.
- Read (en=1, rw=1, rising edge):
  - w_data_out_32 <= {mem[a], mem[a+1], mem[a+2], mem[a+3]}.
  - One-cycle latency: data for the address presented at edge N is visible after edge N.
  - Same wrap and unaligned rules as writes.
- en=0: no storage change; w_data_out_32 holds.
- Back-to-back accesses: one access per cycle, no stall, no ready/valid handshake.
- Reading back an address written on the previous cycle returns the new data.
- A read and a write never coincide (single port, rw selects the operation).
- Uninitialised bytes read as X in simulation. Synthesis initial value: don't-care.
- X or Z on rw or en while en could be 1: the design must not corrupt other locations; only the addressed 4 bytes may become X.

Optional Feature:
- Macro MEM_ACCESS_SIZE_EN.
- When defined, adds input port access_size [1:0]: 00 = byte, 01 = halfword, 10/11 = word.
- Writes with access_size:
  - Byte: writes mem[a] <= din[7:0].
  - Halfword: writes mem[a] <= din[15:8], mem[a+1] <= din[7:0].
- Reads with access_size:
  - Byte: returns {24'h0, mem[a]}.
  - Halfword: returns {16'h0, mem[a], mem[a+1]}.
  - Zero-extended; sign extension is the CPU's job.
- When not defined, the port is absent and every access is a full 32-bit word as described above.

Test Plan:
- Reset: assert reset_n=0 asynchronously mid-cycle after a read of 32'hABCDABCD -> w_data_out_32 = 32'h0 immediately; after release, reading addr 0x0 still returns 32'hABCDABCD (contents preserved).
- Basic word write/read:
  - Writes: 0x0 <= 32'hABCDABCD, 0x4 <= 32'hDEFADEFA, 0x8 <= 32'h12341234.
  - Reads of 0x0, 0x4, 0x8 return those values one cycle after each address edge.
- Bulk load and readback: write 64 sequential words (value = 32'h1000_0000 + i) at addresses 4*i, then switch rw=1 and sweep from 0x0 in +4 steps -> every word matches, one result per cycle.
- Unaligned and endianness:
  - Write 32'h11223344 at 0x0 and 32'h55667788 at 0x4.
  - Read at 0x2 -> 32'h33445566.
  - Read at 0x1 -> 32'h22334455.
- Wrap and aliasing:
  - Write 32'hCAFEBABE at DEPTH_BYTES-2 -> bytes CA,FE land at the top two bytes, BA,BE at bytes 0,1.
  - Read at 0x0 -> 32'hBABExxxx (only the top 16 bits checked).
  - Read at DEPTH_BYTES + (DEPTH_BYTES-2) returns 32'hCAFEBABE.
- Enable gating: with en=0, drive rw=0, addr 0x0, data 32'hFFFFFFFF for 3 cycles -> contents unchanged and w_data_out_32 holds; re-enable a read of 0x0 -> original value returned.
